mc_maindec: RTL and testbench

MC_MAINDEC -- requirements
Module: mc_maindec

---
 rtl/mc_maindec_if.sv | 36 +++
 rtl/mc_maindec.sv | 142 ++++++++++++++
 tb/tb_mc_maindec.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mc_maindec_if.sv
// mc_maindec_if: control bus between the multicycle main decoder and its datapath.
// Ports: op/zero/mem_ready flow into the decoder; the datapath controls and the
// debug state encoding flow out. The decoder uses the master modport and the
// datapath uses the slave modport.
interface mc_maindec_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       IorD;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       Branch;
    logic       PCWrite;
    logic       PCEn;
    logic       illegal;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [1:0] ALUOp;
    logic [3:0] state;

    modport master (
        input  op, zero, mem_ready,
        output IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               Branch, PCWrite, PCEn, illegal, ALUSrcB, PCSrc, ALUOp, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               Branch, PCWrite, PCEn, illegal, ALUSrcB, PCSrc, ALUOp, state
    );
endinterface

// File: rtl/mc_maindec.sv
// mc_maindec: Moore-FSM main decoder for a multicycle MIPS-style datapath.
// Ports: clk (rising-edge clock), reset_n (asynchronous active-low reset),
// bus (mc_maindec_if.master): opcode, ALU zero flag and memory-ready in;
// datapath controls, illegal-opcode flag and debug state encoding out.
module mc_maindec (
    input logic          clk,
    input logic          reset_n,
    mc_maindec_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t st, nx;

    logic       iord, irw, mw, rd, m2r, rw, asa, br, pcw, ill;
    logic [1:0] asb, pcs, aop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) st <= FETCH;
        else          st <= nx;
    end

    always_comb begin
        nx = FETCH;
        case (st)
            FETCH:    nx = bus.mem_ready ? DECODE : FETCH;
            DECODE:   nx = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR   :
                           (bus.op == OP_RTYP)                   ? EXECUTE  :
                           (bus.op == OP_BEQ)                    ? BRANCH   :
                           (bus.op == OP_ADDI)                   ? ADDIEXEC :
                           (bus.op == OP_J)                      ? JUMP     : FETCH;
            MEMADR:   nx = (bus.op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    nx = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:    nx = bus.mem_ready ? FETCH : MEMWR;
            EXECUTE:  nx = ALUWB;
            ADDIEXEC: nx = ADDIWB;
            default:  nx = FETCH;
        endcase
    end

    always_comb begin
        iord = 1'b0;
        irw  = 1'b0;
        mw   = 1'b0;
        rd   = 1'b0;
        m2r  = 1'b0;
        rw   = 1'b0;
        asa  = 1'b0;
        br   = 1'b0;
        pcw  = 1'b0;
        ill  = 1'b0;
        asb  = 2'b00;
        pcs  = 2'b00;
        aop  = 2'b00;
        case (st)
            FETCH: begin
                asb = 2'b01;
                irw = bus.mem_ready;
                pcw = bus.mem_ready;
            end
            DECODE: begin
                asb = 2'b11;
                ill = !(bus.op == OP_LW || bus.op == OP_SW || bus.op == OP_RTYP ||
                        bus.op == OP_BEQ || bus.op == OP_ADDI || bus.op == OP_J);
            end
            MEMADR: begin
                asa = 1'b1;
                asb = 2'b10;
            end
            MEMRD:  iord = 1'b1;
            MEMWB: begin
                m2r = 1'b1;
                rw  = 1'b1;
            end
            MEMWR: begin
                iord = 1'b1;
                mw   = bus.mem_ready;
            end
            EXECUTE: begin
                asa = 1'b1;
                aop = 2'b10;
            end
            ALUWB: begin
                rd = 1'b1;
                rw = 1'b1;
            end
            BRANCH: begin
                asa = 1'b1;
                aop = 2'b01;
                pcs = 2'b01;
                br  = 1'b1;
            end
            ADDIEXEC: begin
                asa = 1'b1;
                asb = 2'b10;
            end
            ADDIWB: rw = 1'b1;
            JUMP: begin
                pcs = 2'b10;
                pcw = 1'b1;
            end
            default: ;
        endcase
    end

    // The state register already sits in FETCH during reset, but FETCH's
    // enables follow mem_ready, so every write enable is also masked by reset_n.
    assign bus.IorD     = iord;
    assign bus.IRWrite  = irw & reset_n;
    assign bus.MemWrite = mw & reset_n;
    assign bus.RegDst   = rd;
    assign bus.MemtoReg = m2r;
    assign bus.RegWrite = rw & reset_n;
    assign bus.ALUSrcA  = asa;
    assign bus.Branch   = br;
    assign bus.PCWrite  = pcw & reset_n;
    assign bus.PCEn     = (pcw & reset_n) | (br & bus.zero);
    assign bus.illegal  = ill & reset_n;
    assign bus.ALUSrcB  = asb;
    assign bus.PCSrc    = pcs;
    assign bus.ALUOp    = aop;
    assign bus.state    = st;
endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: table-driven self-checking bench for mc_maindec.
module tb_mc_maindec;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    mc_maindec_if bus();

    mc_maindec dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Control word: IorD IRWrite MemWrite RegDst MemtoReg RegWrite ALUSrcA
    // Branch PCWrite PCEn illegal | ALUSrcB | PCSrc | ALUOp
    logic [16:0] ctl;
    assign ctl = {bus.IorD, bus.IRWrite, bus.MemWrite, bus.RegDst, bus.MemtoReg,
                  bus.RegWrite, bus.ALUSrcA, bus.Branch, bus.PCWrite, bus.PCEn,
                  bus.illegal, bus.ALUSrcB, bus.PCSrc, bus.ALUOp};

    logic [4:0] wen;
    assign wen = {bus.IRWrite, bus.PCWrite, bus.PCEn, bus.MemWrite, bus.RegWrite};

    localparam logic [16:0] F1   = 17'b0_1_0_0_0_0_0_0_1_1_0_01_00_00;
    localparam logic [16:0] F0   = 17'b0_0_0_0_0_0_0_0_0_0_0_01_00_00;
    localparam logic [16:0] DEC  = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [16:0] DILL = 17'b0_0_0_0_0_0_0_0_0_0_1_11_00_00;
    localparam logic [16:0] MADR = 17'b0_0_0_0_0_0_1_0_0_0_0_10_00_00;
    localparam logic [16:0] MRD  = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] MWB  = 17'b0_0_0_0_1_1_0_0_0_0_0_00_00_00;
    localparam logic [16:0] MWR1 = 17'b1_0_1_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] MWR0 = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] EXE  = 17'b0_0_0_0_0_0_1_0_0_0_0_00_00_10;
    localparam logic [16:0] AWB  = 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_00;
    localparam logic [16:0] BR1  = 17'b0_0_0_0_0_0_1_1_0_1_0_00_01_01;
    localparam logic [16:0] BR0  = 17'b0_0_0_0_0_0_1_1_0_0_0_00_01_01;
    localparam logic [16:0] AIE  = 17'b0_0_0_0_0_0_1_0_0_0_0_10_00_00;
    localparam logic [16:0] AIW  = 17'b0_0_0_0_0_1_0_0_0_0_0_00_00_00;
    localparam logic [16:0] JMP  = 17'b0_0_0_0_0_0_0_0_1_1_0_00_10_00;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] ctl;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic [5:0] op, input logic z, input logic mr,
                       input logic [3:0] s, input logic [16:0] c);
        vec_t v;
        v.op = op; v.zero = z; v.mr = mr; v.st = s; v.ctl = c;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    initial begin
        // lw: 5 cycles
        add(LW, 0, 1, 0, F1);  add(LW, 0, 1, 1, DEC);  add(LW, 0, 1, 2, MADR);
        add(LW, 0, 1, 3, MRD); add(LW, 0, 1, 4, MWB);
        // R-type: 4 cycles
        add(RT, 0, 1, 0, F1);  add(RT, 0, 1, 1, DEC);  add(RT, 0, 1, 6, EXE);
        add(RT, 0, 1, 7, AWB);
        // beq taken, then not taken
        add(BEQ, 1, 1, 0, F1); add(BEQ, 1, 1, 1, DEC); add(BEQ, 1, 1, 8, BR1);
        add(BEQ, 0, 1, 0, F1); add(BEQ, 0, 1, 1, DEC); add(BEQ, 0, 1, 8, BR0);
        // addi: 4 cycles
        add(ADDI, 0, 1, 0, F1); add(ADDI, 0, 1, 1, DEC); add(ADDI, 0, 1, 9, AIE);
        add(ADDI, 0, 1, 10, AIW);
        // j: 3 cycles
        add(J, 0, 1, 0, F1);   add(J, 0, 1, 1, DEC);   add(J, 0, 1, 11, JMP);
        // sw with FETCH stall and 3-cycle MEMWR stall
        add(SW, 0, 0, 0, F0);  add(SW, 0, 1, 0, F1);   add(SW, 0, 0, 1, DEC);
        add(SW, 0, 1, 2, MADR);
        add(SW, 0, 0, 5, MWR0); add(SW, 0, 0, 5, MWR0); add(SW, 0, 0, 5, MWR0);
        add(SW, 0, 1, 5, MWR1);
        // lw with MEMRD stall
        add(LW, 0, 1, 0, F1);  add(LW, 0, 1, 1, DEC);  add(LW, 0, 1, 2, MADR);
        add(LW, 0, 0, 3, MRD); add(LW, 0, 1, 3, MRD);  add(LW, 0, 1, 4, MWB);
        // illegal opcode
        add(BAD, 0, 1, 0, F1); add(BAD, 0, 1, 1, DILL); add(BAD, 0, 0, 0, F0);

        reset_n = 1'b0;
        bus.op = RT;
        bus.zero = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        chk("reset_state", {13'd0, bus.state}, 17'd0);
        chk("reset_ctl", ctl, F0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        bus.zero = 1'b0;

        foreach (vt[i]) begin
            bus.op = vt[i].op;
            bus.zero = vt[i].zero;
            bus.mem_ready = vt[i].mr;
            @(negedge clk);
            chk($sformatf("vec%0d_state", i), {13'd0, bus.state}, {13'd0, vt[i].st});
            chk($sformatf("vec%0d_ctl", i), ctl, vt[i].ctl);
            @(posedge clk);
            #1;
        end

        // Reset pulsed during MEMRD of a lw (FSM is in FETCH with mem_ready=0 here)
        bus.op = LW;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("pre_reset_memrd", {13'd0, bus.state}, 17'd3);
        #1 reset_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        chk("async_reset_state", {13'd0, bus.state}, 17'd0);
        chk("async_reset_wen", {12'd0, wen}, 17'd0);
        chk("async_reset_ill", {16'd0, bus.illegal}, 17'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("in_reset_state%0d", k), {13'd0, bus.state}, 17'd0);
            chk($sformatf("in_reset_wen%0d", k), {12'd0, wen}, 17'd0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_fetch", {13'd0, bus.state}, 17'd0);
        chk("post_reset_ctl", ctl, F1);
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_decode", {13'd0, bus.state}, 17'd1);
        chk("post_reset_no_rw", {16'd0, bus.RegWrite}, 17'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
